// File: rtl/regfile_ctrl_if.sv
// Bundle of the instruction-side and register-file-side signals of regfile_ctrl.
//   slave  : the controller (consumes INSTR/PEIN/DIN/Q0/Q1, drives enables,
//            addresses, write data and status)
//   master : everything around it (instruction source and register file)
// Signal names keep the block's external pin names.
interface regfile_ctrl_if;
   logic [9:0] INSTR;
   logic       PEIN;
   logic [9:0] DIN;
   logic [9:0] Q0;
   logic [9:0] Q1;
   logic       ENW;
   logic       ENR0;
   logic       ENR1;
   logic [1:0] WRA;
   logic [1:0] RDA0;
   logic [1:0] RDA1;
   logic [9:0] DOUT;
   logic       BUSY;
   logic       DONE;
   logic       ERR;
   logic       CARRY;
   logic [7:0] OPCNT;

   modport slave (
      input  INSTR, PEIN, DIN, Q0, Q1,
      output ENW, ENR0, ENR1, WRA, RDA0, RDA1, DOUT, BUSY, DONE, ERR, CARRY, OPCNT
   );

   modport master (
      output INSTR, PEIN, DIN, Q0, Q1,
      input  ENW, ENR0, ENR1, WRA, RDA0, RDA1, DOUT, BUSY, DONE, ERR, CARRY, OPCNT
   );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file controller: accepts LOAD/COPY/ADD/SUB instructions, reads the
// operands through two read ports, writes the result back through the write
// port, and reports completion, illegal opcodes, carry/borrow and a counter of
// completed writes.
// Ports:
//   CLKb  - clock; all state changes on posedge (the register file writes on
//           the following negedge)
//   RSTb  - asynchronous active-low reset
//   bus   - regfile_ctrl_if.slave: INSTR/PEIN/DIN in, Q0/Q1 read data in,
//           ENW/WRA/DOUT write port, ENR0/RDA0 and ENR1/RDA1 read ports,
//           BUSY/DONE/ERR/CARRY/OPCNT status out
module regfile_ctrl (
   input  logic          CLKb,
   input  logic          RSTb,
   regfile_ctrl_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] ERRS  = 2'd3;

   localparam logic [3:0] OP_LOAD = 4'd0;
   localparam logic [3:0] OP_COPY = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;

   logic [1:0] state;
   logic [3:0] op;
   logic [1:0] rx;
   logic [1:0] ry;
   logic [9:0] result;
   logic       carry;
   logic [7:0] opcnt;

   logic [9:0] alu_res;
   logic       alu_carry;
   logic [3:0] new_op;
   logic       unused_bits;

   assign new_op      = bus.INSTR[9:6];
   assign unused_bits = ^bus.INSTR[1:0];

   // Q0 carries Rx, Q1 carries Ry during READ. COPY keeps the old carry.
   always_comb begin
      alu_res   = bus.Q1;
      alu_carry = carry;
      case (op)
         OP_ADD:  {alu_carry, alu_res} = {1'b0, bus.Q0} + {1'b0, bus.Q1};
         OP_SUB: begin
            alu_res   = bus.Q0 - bus.Q1;
            alu_carry = (bus.Q0 < bus.Q1);
         end
         default: begin
            alu_res   = bus.Q1;
            alu_carry = carry;
         end
      endcase
   end

   // OPCNT is bumped on the edge that enters WRITE so the count already
   // includes the write during its DONE cycle.
   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         state  <= IDLE;
         op     <= OP_LOAD;
         rx     <= 2'd0;
         ry     <= 2'd0;
         result <= 10'd0;
         carry  <= 1'b0;
         opcnt  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.PEIN) begin
                  op <= new_op;
                  rx <= bus.INSTR[5:4];
                  ry <= bus.INSTR[3:2];
                  if (new_op == OP_LOAD) begin
                     result <= bus.DIN;
                     opcnt  <= opcnt + 8'd1;
                     state  <= WRITE;
                  end else if (new_op == OP_COPY || new_op == OP_ADD || new_op == OP_SUB) begin
                     state <= READ;
                  end else begin
                     state <= ERRS;
                  end
               end
            end
            READ: begin
               result <= alu_res;
               carry  <= alu_carry;
               opcnt  <= opcnt + 8'd1;
               state  <= WRITE;
            end
            default: state <= IDLE;   // WRITE and ERRS last one cycle
         endcase
      end
   end

   // Outputs decode straight from the state register so an asynchronous reset
   // drops every enable immediately.
   assign bus.ENR0  = (state == READ);
   assign bus.ENR1  = (state == READ);
   assign bus.RDA0  = (state == READ) ? rx : 2'd0;
   assign bus.RDA1  = (state == READ) ? ry : 2'd0;
   assign bus.ENW   = (state == WRITE);
   assign bus.WRA   = (state == WRITE) ? rx : 2'd0;
   assign bus.DOUT  = (state == WRITE) ? result : 10'd0;
   assign bus.DONE  = (state == WRITE);
   assign bus.ERR   = (state == ERRS);
   assign bus.BUSY  = (state != IDLE);
   assign bus.CARRY = carry;
   assign bus.OPCNT = opcnt;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: a 4x10 register file model responds
// to the read/write ports, and an instruction-level model predicts each
// instruction's outputs, carry, counter and register contents.
module tb_regfile_ctrl;

   logic CLKb = 1'b0;
   logic RSTb;
   always #5 CLKb = ~CLKb;

   regfile_ctrl_if bus ();

   regfile_ctrl dut (
      .CLKb (CLKb),
      .RSTb (RSTb),
      .bus  (bus)
   );

   // Register file attached to the controller; reads are don't-care garbage
   // outside READ.
   logic [9:0] rf [4];
   assign bus.Q0 = bus.ENR0 ? rf[bus.RDA0] : 10'h2D3;
   assign bus.Q1 = bus.ENR1 ? rf[bus.RDA1] : 10'h1C6;
   always @(negedge CLKb) if (bus.ENW) rf[bus.WRA] <= bus.DOUT;

   // Instruction-level reference state
   logic [9:0] m_rf [4];
   logic       m_carry;
   logic [7:0] m_opcnt;

   int checks = 0;
   int errors = 0;

   // Issue one instruction at a negedge with the DUT idle, check each cycle
   // up to and including the IDLE cycle that follows.
   task automatic run_op(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                         input logic [9:0] din);
      logic [9:0]  res;
      logic [10:0] sum;
      bus.INSTR = {op, rx, ry, 2'($urandom)};
      bus.DIN   = din;
      bus.PEIN  = 1'b1;
      @(negedge CLKb);
      bus.PEIN  = 1'b0;
      bus.INSTR = 10'($urandom);
      bus.DIN   = 10'($urandom);
      if (op > 4'd3) begin
         checks++;
         if ({bus.ERR, bus.BUSY, bus.ENW, bus.DONE, bus.WRA, bus.DOUT, bus.OPCNT} !==
             {1'b1, 1'b1, 1'b0, 1'b0, 2'b0, 10'b0, m_opcnt}) begin
            errors++;
            $display("FAIL err_cycle op=%h got %h exp %h", op,
               {bus.ERR, bus.BUSY, bus.ENW, bus.DONE, bus.WRA, bus.DOUT, bus.OPCNT},
               {1'b1, 1'b1, 1'b0, 1'b0, 2'b0, 10'b0, m_opcnt});
         end
         @(negedge CLKb);
         checks++;
         if ({bus.ERR, bus.BUSY, bus.ENW, bus.OPCNT} !== {1'b0, 1'b0, 1'b0, m_opcnt}) begin
            errors++;
            $display("FAIL err_after got %h exp %h", {bus.ERR, bus.BUSY, bus.ENW, bus.OPCNT},
               {1'b0, 1'b0, 1'b0, m_opcnt});
         end
         return;
      end
      if (op != 4'd0) begin
         checks++;
         if ({bus.BUSY, bus.ENR0, bus.RDA0, bus.ENR1, bus.RDA1, bus.ENW, bus.WRA, bus.DOUT, bus.DONE, bus.ERR} !==
             {1'b1, 1'b1, rx, 1'b1, ry, 1'b0, 2'b0, 10'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_cycle op=%h got %h exp %h", op,
               {bus.BUSY, bus.ENR0, bus.RDA0, bus.ENR1, bus.RDA1, bus.ENW, bus.WRA, bus.DOUT, bus.DONE, bus.ERR},
               {1'b1, 1'b1, rx, 1'b1, ry, 1'b0, 2'b0, 10'b0, 1'b0, 1'b0});
         end
         @(negedge CLKb);
      end
      case (op)
         4'd0: res = din;
         4'd1: res = m_rf[ry];
         4'd2: begin
            sum     = {1'b0, m_rf[rx]} + {1'b0, m_rf[ry]};
            res     = sum[9:0];
            m_carry = sum[10];
         end
         default: begin
            res     = 10'((int'(m_rf[rx]) - int'(m_rf[ry]) + 1024) % 1024);
            m_carry = (m_rf[rx] < m_rf[ry]);
         end
      endcase
      m_rf[rx] = res;
      m_opcnt  = m_opcnt + 8'd1;
      checks++;
      if ({bus.BUSY, bus.ENW, bus.WRA, bus.DOUT, bus.DONE, bus.ERR, bus.ENR0, bus.ENR1, bus.RDA0, bus.RDA1, bus.CARRY, bus.OPCNT} !==
          {1'b1, 1'b1, rx, res, 1'b1, 1'b0, 1'b0, 1'b0, 2'b0, 2'b0, m_carry, m_opcnt}) begin
         errors++;
         $display("FAIL write_cycle op=%h got %h exp %h", op,
            {bus.BUSY, bus.ENW, bus.WRA, bus.DOUT, bus.DONE, bus.ERR, bus.ENR0, bus.ENR1, bus.RDA0, bus.RDA1, bus.CARRY, bus.OPCNT},
            {1'b1, 1'b1, rx, res, 1'b1, 1'b0, 1'b0, 1'b0, 2'b0, 2'b0, m_carry, m_opcnt});
      end
      @(negedge CLKb);
      checks++;
      if ({bus.BUSY, bus.DONE, bus.ERR, bus.ENW, bus.WRA, bus.DOUT, bus.ENR0, bus.ENR1} !== 17'd0) begin
         errors++;
         $display("FAIL idle_after got %h exp 0",
            {bus.BUSY, bus.DONE, bus.ERR, bus.ENW, bus.WRA, bus.DOUT, bus.ENR0, bus.ENR1});
      end
   endtask

   task automatic test_reset();
      RSTb      = 1'b0;
      bus.PEIN  = 1'b1;              // must be ignored while in reset
      bus.INSTR = 10'b0000_10_00_00;
      bus.DIN   = 10'h3FF;
      repeat (2) @(negedge CLKb);
      checks++;
      if ({bus.ENW, bus.ENR0, bus.ENR1, bus.WRA, bus.RDA0, bus.RDA1, bus.DOUT, bus.BUSY, bus.DONE, bus.ERR, bus.CARRY, bus.OPCNT} !== 31'd0) begin
         errors++;
         $display("FAIL reset_state got %h exp 0",
            {bus.ENW, bus.ENR0, bus.ENR1, bus.WRA, bus.RDA0, bus.RDA1, bus.DOUT, bus.BUSY, bus.DONE, bus.ERR, bus.CARRY, bus.OPCNT});
      end
      bus.PEIN = 1'b0;
      RSTb     = 1'b1;
      m_carry  = 1'b0;
      m_opcnt  = 8'd0;
      @(negedge CLKb);
   endtask

   task automatic test_load();
      run_op(4'd0, 2'd2, 2'd0, 10'h155);   // OPCNT=1 in its WRITE cycle
      run_op(4'd0, 2'd0, 2'd1, 10'($urandom));
      run_op(4'd0, 2'd1, 2'd3, 10'($urandom));
      run_op(4'd0, 2'd3, 2'd2, 10'($urandom));
   endtask

   task automatic test_add_carry();
      run_op(4'd0, 2'd1, 2'd0, 10'h3FF);
      run_op(4'd0, 2'd3, 2'd0, 10'h002);
      run_op(4'd2, 2'd1, 2'd3, 10'($urandom));   // 0x3FF+2 -> 0x001, carry 1
      run_op(4'd0, 2'd2, 2'd0, 10'h123);
      run_op(4'd2, 2'd2, 2'd2, 10'($urandom));   // Rx=Ry doubles R2
   endtask

   task automatic test_sub_borrow();
      run_op(4'd0, 2'd0, 2'd0, 10'h005);
      run_op(4'd0, 2'd1, 2'd0, 10'h007);
      run_op(4'd3, 2'd0, 2'd1, 10'($urandom));   // 5-7 -> 0x3FE, borrow
      run_op(4'd1, 2'd2, 2'd0, 10'($urandom));   // carry left at 1
      run_op(4'd0, 2'd3, 2'd0, 10'h000);          // LOAD also leaves it
   endtask

   task automatic test_illegal();
      run_op(4'hF, 2'd1, 2'd2, 10'h3AA);
      for (int i = 0; i < 4; i++)
         run_op(4'($urandom_range(4, 14)), 2'($urandom), 2'($urandom), 10'($urandom));
   endtask

   // ADD accepted, PEIN kept high with a LOAD on INSTR: the LOAD must only be
   // taken on the IDLE cycle after the ADD's WRITE.
   task automatic test_busy_ignore();
      logic [10:0] sum;
      bus.INSTR = {4'd2, 2'd0, 2'd3, 2'b0};
      bus.PEIN  = 1'b1;
      @(negedge CLKb);
      bus.INSTR = {4'd0, 2'd0, 2'd0, 2'b0};
      bus.DIN   = 10'h2AA;
      checks++;
      if ({bus.ENR0, bus.RDA0, bus.RDA1, bus.ENW} !== {1'b1, 2'd0, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL busy_read got %h exp %h", {bus.ENR0, bus.RDA0, bus.RDA1, bus.ENW}, {1'b1, 2'd0, 2'd3, 1'b0});
      end
      @(negedge CLKb);
      sum      = {1'b0, m_rf[0]} + {1'b0, m_rf[3]};
      m_rf[0]  = sum[9:0];
      m_carry  = sum[10];
      m_opcnt  = m_opcnt + 8'd1;
      checks++;
      if ({bus.ENW, bus.WRA, bus.DOUT, bus.CARRY, bus.OPCNT} !== {1'b1, 2'd0, sum[9:0], m_carry, m_opcnt}) begin
         errors++;
         $display("FAIL busy_write got %h exp %h", {bus.ENW, bus.WRA, bus.DOUT, bus.CARRY, bus.OPCNT},
            {1'b1, 2'd0, sum[9:0], m_carry, m_opcnt});
      end
      @(negedge CLKb);
      checks++;
      if ({bus.BUSY, bus.ENW} !== 2'b00) begin
         errors++;
         $display("FAIL busy_idle got %b exp 00", {bus.BUSY, bus.ENW});
      end
      @(negedge CLKb);
      bus.PEIN = 1'b0;
      m_rf[0]  = 10'h2AA;
      m_opcnt  = m_opcnt + 8'd1;
      checks++;
      if ({bus.ENW, bus.WRA, bus.DOUT, bus.OPCNT} !== {1'b1, 2'd0, 10'h2AA, m_opcnt}) begin
         errors++;
         $display("FAIL busy_held_load got %h exp %h", {bus.ENW, bus.WRA, bus.DOUT, bus.OPCNT},
            {1'b1, 2'd0, 10'h2AA, m_opcnt});
      end
      @(negedge CLKb);
   endtask

   // PEIN held high with a fresh LOAD every cycle: DONE every other cycle,
   // and only the instructions presented in IDLE cycles get written.
   task automatic test_back_to_back();
      logic [1:0] p_rx;
      logic [9:0] p_din;
      p_rx  = 2'd0;
      p_din = 10'd0;
      for (int k = 0; k <= 8; k++) begin
         if (k % 2 == 1) begin
            m_rf[p_rx] = p_din;
            m_opcnt    = m_opcnt + 8'd1;
            checks++;
            if ({bus.DONE, bus.ENW, bus.WRA, bus.DOUT, bus.OPCNT} !== {1'b1, 1'b1, p_rx, p_din, m_opcnt}) begin
               errors++;
               $display("FAIL b2b_write k=%0d got %h exp %h", k, {bus.DONE, bus.ENW, bus.WRA, bus.DOUT, bus.OPCNT},
                  {1'b1, 1'b1, p_rx, p_din, m_opcnt});
            end
         end else if (k > 0) begin
            checks++;
            if ({bus.DONE, bus.BUSY, bus.ENW} !== 3'b000) begin
               errors++;
               $display("FAIL b2b_gap k=%0d got %b exp 000", k, {bus.DONE, bus.BUSY, bus.ENW});
            end
         end
         if (k == 8) begin
            bus.PEIN = 1'b0;
         end else begin
            bus.PEIN  = 1'b1;
            bus.INSTR = {4'd0, 2'($urandom), 4'($urandom)};
            bus.DIN   = 10'($urandom);
            if (k % 2 == 0) begin
               p_rx  = bus.INSTR[5:4];
               p_din = bus.DIN;
            end
         end
         @(negedge CLKb);
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 4));
         if (op == 4'd4) op = 4'($urandom_range(4, 15));
         run_op(op, 2'($urandom), 2'($urandom), 10'($urandom));
      end
   endtask

   task automatic test_rf_contents();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rf[i] !== m_rf[i]) begin
            errors++;
            $display("FAIL rf_contents R%0d got %h exp %h", i, rf[i], m_rf[i]);
         end
      end
   endtask

   // Reset mid-READ: enables drop with no clock edge, no write follows, and
   // the first instruction after release is taken on the next posedge.
   task automatic test_reset_mid();
      bus.INSTR = {4'd2, 2'd0, 2'd1, 2'b0};
      bus.PEIN  = 1'b1;
      @(negedge CLKb);
      bus.PEIN = 1'b0;
      checks++;
      if ({bus.ENR0, bus.ENR1, bus.BUSY} !== 3'b111) begin
         errors++;
         $display("FAIL rst_mid_read got %b exp 111", {bus.ENR0, bus.ENR1, bus.BUSY});
      end
      #2 RSTb = 1'b0;
      #1;
      checks++;
      if ({bus.ENR0, bus.ENR1, bus.BUSY, bus.ENW, bus.RDA0, bus.RDA1, bus.CARRY, bus.OPCNT} !== 17'd0) begin
         errors++;
         $display("FAIL rst_async got %h exp 0",
            {bus.ENR0, bus.ENR1, bus.BUSY, bus.ENW, bus.RDA0, bus.RDA1, bus.CARRY, bus.OPCNT});
      end
      @(negedge CLKb);
      checks++;
      if ({bus.ENW, bus.DONE, bus.OPCNT} !== 10'd0) begin
         errors++;
         $display("FAIL rst_no_write got %h exp 0", {bus.ENW, bus.DONE, bus.OPCNT});
      end
      RSTb    = 1'b1;
      m_carry = 1'b0;
      m_opcnt = 8'd0;
      run_op(4'd0, 2'd3, 2'd0, 10'h0F0);   // first edge after release, OPCNT=1
      test_rf_contents();                   // R0 untouched by the aborted ADD
   endtask

   initial begin
      bus.PEIN  = 1'b0;
      bus.INSTR = 10'd0;
      bus.DIN   = 10'd0;
      for (int i = 0; i < 4; i++) m_rf[i] = 10'd0;
      m_carry = 1'b0;
      m_opcnt = 8'd0;
      test_reset();
      test_load();
      test_add_carry();
      test_sub_borrow();
      test_illegal();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      test_rf_contents();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have port CLKb, input, 1 bit: single clock; all state updates on posedge CLKb, so register-file writes land on the following negedge.
REQ-002 SHALL have port RSTb, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port INSTR, input, 10 bits: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored.
REQ-004 SHALL have port PEIN, input, 1 bit: instruction valid.
REQ-005 SHALL have port DIN, input, 10 bits: external data for LOAD.
REQ-006 SHALL have ports Q0 and Q1, input, 10 bits each: register-file read data.
REQ-007 SHALL have ports ENW, ENR0 and ENR1, output, 1 bit each: register-file enables.
REQ-008 SHALL have ports WRA, RDA0 and RDA1, output, 2 bits each: register-file addresses.
REQ-009 SHALL have port DOUT, output, 10 bits: register-file write data (D).
REQ-010 SHALL have port BUSY, output, 1 bit: high when state is not IDLE.
REQ-011 SHALL have port DONE, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port ERR, output, 1 bit: single-cycle illegal-opcode pulse.
REQ-013 SHALL have port CARRY, output, 1 bit: carry/borrow of last ADD/SUB.
REQ-014 SHALL have port OPCNT, output, 8 bits: completed-write counter.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE and ERRS, all registered.
REQ-016 SHALL accept an instruction only when state is IDLE and PEIN=1 at a posedge, latching INSTR (and DIN for LOAD); PEIN in any other state SHALL be ignored.
REQ-017 SHALL decode opcode 0000 as LOAD (Rx<-DIN), 0001 as COPY (Rx<-Ry), 0010 as ADD (Rx<-Rx+Ry) and 0011 as SUB (Rx<-Rx-Ry); every other opcode is illegal.
REQ-018 SHALL make the accepting edge go to READ for COPY/ADD/SUB, to WRITE for LOAD, and to ERRS for illegal opcodes.
REQ-019 SHALL, in READ (one cycle), drive ENR0=1, RDA0=Rx, ENR1=1, RDA1=Ry, and at the closing posedge register the result and go to WRITE.
REQ-020 SHALL compute the result as Q1 for COPY, (Q0+Q1) mod 1024 for ADD with CARRY=bit 10 of the sum, and (Q0-Q1) mod 1024 for SUB with CARRY=1 when Q0<Q1 (unsigned borrow).
REQ-021 SHALL leave CARRY unchanged by LOAD and COPY.
REQ-022 SHALL, in WRITE (one cycle), drive ENW=1, WRA=Rx and DOUT=registered result, assert DONE=1, increment OPCNT (wrapping 255->0), and return to IDLE.
REQ-023 SHALL, in ERRS (one cycle), assert ERR=1 with ENW=0 and OPCNT unchanged, then return to IDLE.
REQ-024 SHALL, outside READ, drive ENR0=ENR1=0 and RDA0=RDA1=00; outside WRITE it SHALL drive ENW=0, WRA=00 and DOUT=0.
REQ-025 SHALL give latency from accepting edge to DONE cycle of 1 cycle for LOAD and 2 cycles for COPY/ADD/SUB; the next instruction is acceptable on the edge that ends WRITE/ERRS+1 (state IDLE).
REQ-026 SHALL handle Rx=Ry correctly (e.g. ADD R1,R1 doubles R1).
REQ-027 SHALL treat Q0/Q1 as don't-care outside READ.

Reset
REQ-028 SHALL, on RSTb=0, immediately (asynchronously) force state IDLE, ENW=ENR0=ENR1=0, all addresses 00, DOUT=0, BUSY=DONE=ERR=0, CARRY=0 and OPCNT=0.
REQ-029 SHALL abort any instruction in flight when reset is asserted mid-operation, with no write issued, and SHALL accept the first instruction at the first posedge after RSTb rises.

Verification
REQ-030 SHALL be verified with LOAD R2, DIN=0x155 -> next cycle ENW=1, WRA=2, DOUT=0x155, DONE=1, OPCNT=1.
REQ-031 SHALL be verified with ADD R1,R3 where Q0=0x3FF and Q1=0x002 -> READ cycle RDA0=1, RDA1=3; WRITE cycle DOUT=0x001, WRA=1, CARRY=1.
REQ-032 SHALL be verified with SUB R0,R1 where Q0=0x005 and Q1=0x007 -> DOUT=0x3FE, CARRY=1; then COPY -> CARRY still 1.
REQ-033 SHALL be verified with opcode 1111 -> ERR=1 for one cycle, ENW stays 0, OPCNT unchanged, BUSY high for exactly one cycle.
REQ-034 SHALL be verified with PEIN held high during a busy ADD -> second INSTR ignored until IDLE; back-to-back LOADs give DONE every 2 cycles.
REQ-035 SHALL be verified with RSTb pulsed low during READ -> ENR0/ENR1 drop without waiting for a clock, no ENW pulse, and OPCNT=0.
